cpu_reg_bank: RTL and testbench

// - Parametrised, clocked bank of 6502 CPU registers (AC, X, Y, SP) replacing per-register latches.
// - Each register loads from the system bus and drives the system bus and data bus (wired-AND, idle all-ones).
// - Each register supports increment/decrement and decimal-adjust add; N/Z status flags are registered for the CPU flag logic.

---
 rtl/cpu_regs_pkg.sv | 19 +
 rtl/cpu_reg_cell.sv | 54 +++++
 rtl/cpu_reg_bank.sv | 114 +++++++++++
 tb/tb_cpu_reg_bank.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regs_pkg.sv
// Shared types and constants for the 6502 register bank.
package cpu_regs_pkg;

    typedef enum logic [1:0] {
        REG_AC = 2'd0,
        REG_X  = 2'd1,
        REG_Y  = 2'd2,
        REG_SP = 2'd3
    } reg_idx_t;

    localparam logic [7:0]  SP_RESET_DEFAULT = 8'hFD;
    localparam int unsigned MAX_WIDTH        = 64;

    // Idle bus level; callers truncate to their own width.
    function automatic logic [MAX_WIDTH-1:0] BUS_IDLE();
        return '1;
    endfunction

endpackage

// File: rtl/cpu_reg_cell.sv
// One bank register: load > decimal-adjust > inc/dec > hold, modulo 2^WIDTH.
module cpu_reg_cell
    import cpu_regs_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             adj_i,
    input  logic [WIDTH-1:0] adj_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] next_o,
    output logic             mod_o
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    logic             mod;

    always_comb begin
        val_d = val_q;
        mod   = 1'b1;
        if (load_i) begin
            val_d = load_val_i;
        end else if (adj_i) begin
            // Decimal carry comes from the ALU, so the overflow bit is dropped here.
            val_d = val_q + adj_val_i;
        end else if (inc_i && !dec_i) begin
            val_d = val_q + WIDTH'(1);
        end else if (dec_i && !inc_i) begin
            val_d = val_q - WIDTH'(1);
        end else begin
            mod = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= RESET_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o    = val_q;
    assign next_o = val_d;
    assign mod_o  = mod;

endmodule

// File: rtl/cpu_reg_bank.sv
// Clocked bank of 6502 registers (AC, X, Y, SP) with idle-high bus drivers and registered N/Z.
module cpu_reg_bank
    import cpu_regs_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      NUM_REGS = 4,
    parameter int unsigned      SP_INDEX = 3,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_RESET_DEFAULT),
    localparam int unsigned     IDXW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic [WIDTH-1:0] systemBus_IN,
    input  logic             systemBusRead_EN,
    input  logic [IDXW-1:0]  loadSel,
    input  logic             systemBusWrite_EN,
    input  logic [IDXW-1:0]  sysSel,
    input  logic             dataBusWrite_EN,
    input  logic [IDXW-1:0]  dataSel,
    input  logic             inc_EN,
    input  logic             dec_EN,
    input  logic [IDXW-1:0]  incDecSel,
    input  logic             decAdjust_EN,
    input  logic [WIDTH-1:0] decAdjustAdders,
    output logic [WIDTH-1:0] systemBus_OUT,
    output logic [WIDTH-1:0] dataBus_OUT,
    output logic             negative_OUT,
    output logic             zero_OUT
);

    localparam logic [WIDTH-1:0] IDLE = WIDTH'(BUS_IDLE());

    logic [NUM_REGS-1:0][WIDTH-1:0] q;
    logic [NUM_REGS-1:0][WIDTH-1:0] nxt;
    logic [NUM_REGS-1:0]            mod;
    logic [NUM_REGS-1:0]            ld_hit;
    logic [NUM_REGS-1:0]            adj_hit;
    logic [NUM_REGS-1:0]            inc_hit;
    logic [NUM_REGS-1:0]            dec_hit;

    // Out-of-range selects match no cell, so the operation is simply ignored.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign ld_hit[i]  = systemBusRead_EN && (loadSel == IDXW'(i));
        assign adj_hit[i] = decAdjust_EN && (loadSel == IDXW'(i));
        assign inc_hit[i] = inc_EN && (incDecSel == IDXW'(i));
        assign dec_hit[i] = dec_EN && (incDecSel == IDXW'(i));

        cpu_reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL ((i == SP_INDEX) ? SP_RESET : {WIDTH{1'b0}})
        ) u_cell (
            .clk_i      (clk),
            .rst_ni     (reset_N),
            .load_i     (ld_hit[i]),
            .load_val_i (systemBus_IN),
            .adj_i      (adj_hit[i]),
            .adj_val_i  (decAdjustAdders),
            .inc_i      (inc_hit[i]),
            .dec_i      (dec_hit[i]),
            .q_o        (q[i]),
            .next_o     (nxt[i]),
            .mod_o      (mod[i])
        );
    end

    // Idle level is all-ones so several banks can share a wired-AND bus.
    always_comb begin
        systemBus_OUT = IDLE;
        dataBus_OUT   = IDLE;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset_N && systemBusWrite_EN && (sysSel == IDXW'(i))) begin
                systemBus_OUT = q[i];
            end
            if (reset_N && dataBusWrite_EN && (dataSel == IDXW'(i))) begin
                dataBus_OUT = q[i];
            end
        end
    end

    logic             n_q, n_d;
    logic             z_q, z_d;
    logic [WIDTH-1:0] flag_src;

    // A load/adjust result takes precedence over a concurrent inc/dec on another register.
    always_comb begin
        flag_src = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((inc_hit[i] || dec_hit[i]) && mod[i]) begin
                flag_src = nxt[i];
            end
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ld_hit[i] || adj_hit[i]) begin
                flag_src = nxt[i];
            end
        end
        n_d = (|mod) ? flag_src[WIDTH-1] : n_q;
        z_d = (|mod) ? (flag_src == '0) : z_q;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            n_q <= n_d;
            z_q <= z_d;
        end
    end

    assign negative_OUT = n_q;
    assign zero_OUT     = z_q;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Directed self-checking bench for cpu_reg_bank, including a two-bank wired-AND bus.
module tb_cpu_reg_bank;
    import cpu_regs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] sys_in, adj_val, sys_out, data_out;
    logic [1:0] load_sel, sys_sel, data_sel, incdec_sel;
    logic       sys_rd, sys_wr, data_wr, inc_en, dec_en, adj_en, neg, zero;

    logic [7:0] b_sys_in, b_adj_val, b_sys_out, b_data_out;
    logic [1:0] b_load_sel, b_sys_sel, b_data_sel, b_incdec_sel;
    logic       b_sys_rd, b_sys_wr, b_data_wr, b_inc_en, b_dec_en, b_adj_en, b_neg, b_zero;

    wire  [7:0] shared_bus = data_out & b_data_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_rst [4] = '{8'h00, 8'h00, 8'h00, 8'hFD};

    cpu_reg_bank u_dut (
        .clk               (clk),
        .reset_N           (reset_n),
        .systemBus_IN      (sys_in),
        .systemBusRead_EN  (sys_rd),
        .loadSel           (load_sel),
        .systemBusWrite_EN (sys_wr),
        .sysSel            (sys_sel),
        .dataBusWrite_EN   (data_wr),
        .dataSel           (data_sel),
        .inc_EN            (inc_en),
        .dec_EN            (dec_en),
        .incDecSel         (incdec_sel),
        .decAdjust_EN      (adj_en),
        .decAdjustAdders   (adj_val),
        .systemBus_OUT     (sys_out),
        .dataBus_OUT       (data_out),
        .negative_OUT      (neg),
        .zero_OUT          (zero)
    );

    cpu_reg_bank u_dut_b (
        .clk               (clk),
        .reset_N           (reset_n),
        .systemBus_IN      (b_sys_in),
        .systemBusRead_EN  (b_sys_rd),
        .loadSel           (b_load_sel),
        .systemBusWrite_EN (b_sys_wr),
        .sysSel            (b_sys_sel),
        .dataBusWrite_EN   (b_data_wr),
        .dataSel           (b_data_sel),
        .inc_EN            (b_inc_en),
        .dec_EN            (b_dec_en),
        .incDecSel         (b_incdec_sel),
        .decAdjust_EN      (b_adj_en),
        .decAdjustAdders   (b_adj_val),
        .systemBus_OUT     (b_sys_out),
        .dataBus_OUT       (b_data_out),
        .negative_OUT      (b_neg),
        .zero_OUT          (b_zero)
    );

    task automatic clear_ctrl();
        sys_in = 8'h00; adj_val = 8'h00;
        load_sel = 2'd0; sys_sel = 2'd0; data_sel = 2'd0; incdec_sel = 2'd0;
        sys_rd = 1'b0; sys_wr = 1'b0; data_wr = 1'b0;
        inc_en = 1'b0; dec_en = 1'b0; adj_en = 1'b0;
    endtask

    task automatic clear_b();
        b_sys_in = 8'h00; b_adj_val = 8'h00;
        b_load_sel = 2'd0; b_sys_sel = 2'd0; b_data_sel = 2'd0; b_incdec_sel = 2'd0;
        b_sys_rd = 1'b0; b_sys_wr = 1'b0; b_data_wr = 1'b0;
        b_inc_en = 1'b0; b_dec_en = 1'b0; b_adj_en = 1'b0;
    endtask

    // Apply the edge, then drop all controls 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic read_sys(input logic [1:0] idx);
        sys_wr = 1'b1;
        sys_sel = idx;
        #1;
    endtask

    task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
        clear_ctrl();
        load_sel = idx; sys_in = val; sys_rd = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_ctrl();
        clear_b();
        sys_wr = 1'b1; sys_sel = REG_AC; data_wr = 1'b1; data_sel = REG_SP;
        #1;
        n_cmp++; if (sys_out !== 8'hFF) begin
            n_bad++; $display("FAIL reset_sysbus: got %h want ff", sys_out); end
        n_cmp++; if (data_out !== 8'hFF) begin
            n_bad++; $display("FAIL reset_databus: got %h want ff", data_out); end
        @(negedge clk);
        reset_n = 1'b1;
        clear_ctrl();
        load_sel = REG_X; sys_in = 8'h33; sys_rd = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 clear_ctrl();
        #1 reset_n = 1'b1;
        n_cmp++; if (neg !== 1'b0) begin
            n_bad++; $display("FAIL reset_n_flag: got %b want 0", neg); end
        n_cmp++; if (zero !== 1'b0) begin
            n_bad++; $display("FAIL reset_z_flag: got %b want 0", zero); end
        for (int i = 0; i < 4; i++) begin
            read_sys(2'(i));
            n_cmp++; if (sys_out !== exp_rst[i]) begin
                n_bad++; $display("FAIL reset_reg%0d: got %h want %h", i, sys_out, exp_rst[i]);
            end
        end
        n_cmp++; if (data_out !== 8'hFF) begin
            n_bad++; $display("FAIL reset_data_idle: got %h want ff", data_out); end
        clear_ctrl();
    endtask

    task automatic test_load_drive();
        clear_ctrl();
        load_sel = REG_X; sys_in = 8'h80; sys_rd = 1'b1;
        sys_wr = 1'b1; sys_sel = REG_X;
        #1;
        n_cmp++; if (sys_out !== 8'h00) begin
            n_bad++; $display("FAIL load_same_cycle_old: got %h want 00", sys_out); end
        tick();
        read_sys(REG_X);
        n_cmp++; if (sys_out !== 8'h80) begin
            n_bad++; $display("FAIL load_x_sysbus: got %h want 80", sys_out); end
        n_cmp++; if (data_out !== 8'hFF) begin
            n_bad++; $display("FAIL load_x_data_idle: got %h want ff", data_out); end
        n_cmp++; if (neg !== 1'b1 || zero !== 1'b0) begin
            n_bad++; $display("FAIL load_x_flags: got N%b Z%b want N1 Z0", neg, zero); end
        data_wr = 1'b1; data_sel = REG_X; #1;
        n_cmp++; if (data_out !== 8'h80) begin
            n_bad++; $display("FAIL load_x_databus: got %h want 80", data_out); end
        clear_ctrl();
    endtask

    task automatic test_wrap();
        load_reg(REG_SP, 8'h00);
        dec_en = 1'b1; incdec_sel = REG_SP;
        tick();
        read_sys(REG_SP);
        n_cmp++; if (sys_out !== 8'hFF) begin
            n_bad++; $display("FAIL dec_sp_wrap: got %h want ff", sys_out); end
        n_cmp++; if (neg !== 1'b1 || zero !== 1'b0) begin
            n_bad++; $display("FAIL dec_sp_flags: got N%b Z%b want N1 Z0", neg, zero); end
        load_reg(REG_Y, 8'hFF);
        inc_en = 1'b1; incdec_sel = REG_Y;
        tick();
        read_sys(REG_Y);
        n_cmp++; if (sys_out !== 8'h00) begin
            n_bad++; $display("FAIL inc_y_wrap: got %h want 00", sys_out); end
        n_cmp++; if (neg !== 1'b0 || zero !== 1'b1) begin
            n_bad++; $display("FAIL inc_y_flags: got N%b Z%b want N0 Z1", neg, zero); end
        clear_ctrl();
        inc_en = 1'b1; dec_en = 1'b1; incdec_sel = REG_X;
        tick();
        read_sys(REG_X);
        n_cmp++; if (sys_out !== 8'h80) begin
            n_bad++; $display("FAIL incdec_cancel_x: got %h want 80", sys_out); end
        n_cmp++; if (neg !== 1'b0 || zero !== 1'b1) begin
            n_bad++; $display("FAIL incdec_cancel_flags: got N%b Z%b want N0 Z1", neg, zero); end
        clear_ctrl();
    endtask

    task automatic test_dec_adjust();
        load_reg(REG_AC, 8'h0F);
        adj_en = 1'b1; load_sel = REG_AC; adj_val = 8'hFA;
        tick();
        read_sys(REG_AC);
        n_cmp++; if (sys_out !== 8'h09) begin
            n_bad++; $display("FAIL adj_0f_fa: got %h want 09", sys_out); end
        n_cmp++; if (neg !== 1'b0 || zero !== 1'b0) begin
            n_bad++; $display("FAIL adj_0f_flags: got N%b Z%b want N0 Z0", neg, zero); end
        load_reg(REG_AC, 8'h9A);
        adj_en = 1'b1; load_sel = REG_AC; adj_val = 8'h66;
        tick();
        read_sys(REG_AC);
        n_cmp++; if (sys_out !== 8'h00) begin
            n_bad++; $display("FAIL adj_9a_66: got %h want 00", sys_out); end
        n_cmp++; if (neg !== 1'b0 || zero !== 1'b1) begin
            n_bad++; $display("FAIL adj_9a_flags: got N%b Z%b want N0 Z1", neg, zero); end
        clear_ctrl();
        sys_rd = 1'b1; adj_en = 1'b1; load_sel = REG_AC; sys_in = 8'h42; adj_val = 8'h06;
        tick();
        read_sys(REG_AC);
        n_cmp++; if (sys_out !== 8'h42) begin
            n_bad++; $display("FAIL load_beats_adj: got %h want 42", sys_out); end
        clear_ctrl();
    endtask

    task automatic test_concurrency();
        load_reg(REG_X, 8'h10);
        dec_en = 1'b1; incdec_sel = REG_Y;
        tick();
        tick();
        n_cmp++; if (neg !== 1'b1 || zero !== 1'b0) begin
            n_bad++; $display("FAIL flags_hold: got N%b Z%b want N1 Z0", neg, zero); end
        sys_rd = 1'b1; load_sel = REG_AC; sys_in = 8'h55;
        inc_en = 1'b1; incdec_sel = REG_X;
        tick();
        read_sys(REG_AC);
        n_cmp++; if (sys_out !== 8'h55) begin
            n_bad++; $display("FAIL conc_ac: got %h want 55", sys_out); end
        read_sys(REG_X);
        n_cmp++; if (sys_out !== 8'h11) begin
            n_bad++; $display("FAIL conc_x: got %h want 11", sys_out); end
        n_cmp++; if (neg !== 1'b0 || zero !== 1'b0) begin
            n_bad++; $display("FAIL conc_flags: got N%b Z%b want N0 Z0", neg, zero); end
        clear_ctrl();
    endtask

    task automatic test_back_to_back();
        load_reg(REG_AC, 8'hA1);
        load_reg(REG_X, 8'hB2);
        load_reg(REG_Y, 8'hC3);
        data_wr = 1'b1; data_sel = REG_X; #1;
        n_cmp++; if (data_out !== 8'hB2) begin
            n_bad++; $display("FAIL b2b_x: got %h want b2", data_out); end
        data_sel = REG_Y; #1;
        n_cmp++; if (data_out !== 8'hC3) begin
            n_bad++; $display("FAIL b2b_y: got %h want c3", data_out); end
        n_cmp++; if (neg !== 1'b1 || zero !== 1'b0) begin
            n_bad++; $display("FAIL b2b_flags: got N%b Z%b want N1 Z0", neg, zero); end
        clear_ctrl();
    endtask

    task automatic test_wired_and();
        clear_ctrl();
        b_sys_rd = 1'b1; b_load_sel = REG_AC; b_sys_in = 8'h0F;
        @(posedge clk);
        #1 clear_b();
        b_data_wr = 1'b1; b_data_sel = REG_AC; #1;
        n_cmp++; if (shared_bus !== 8'h0F) begin
            n_bad++; $display("FAIL wand_one_driver: got %h want 0f", shared_bus); end
        b_data_wr = 1'b0; #1;
        n_cmp++; if (shared_bus !== 8'hFF) begin
            n_bad++; $display("FAIL wand_both_idle: got %h want ff", shared_bus); end
        b_data_wr = 1'b1; data_wr = 1'b1; data_sel = REG_AC; #1;
        n_cmp++; if (shared_bus !== 8'h01) begin
            n_bad++; $display("FAIL wand_both_drive: got %h want 01", shared_bus); end
        clear_b();
        clear_ctrl();
    endtask

    initial begin
        test_reset();
        test_load_drive();
        test_wrap();
        test_dec_adjust();
        test_concurrency();
        test_back_to_back();
        test_wired_and();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
